// File: rtl/phy_rx_serial_paral_pkg.sv
// Shared types and constants for the per-lane PHY RX deserializer.
package phy_rx_pkg;

  localparam logic [7:0]  COM_BYTE_DEF = 8'hBC;
  localparam int unsigned COM_CNT_W    = 4;

  typedef enum logic {
    SEARCH = 1'b0,
    ACTIVE = 1'b1
  } rx_state_e;

  // Saturating increment for the COM run counter; it never wraps.
  function automatic logic [COM_CNT_W-1:0] sat_inc(input logic [COM_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/phy_rx_serial_paral_if.sv
// Serial-in / byte-out bundle of one RX lane.
// master: the side feeding serial data and consuming bytes; slave: the deserializer.
interface phy_rx_serial_paral_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (output serial_in, input data_out, valid_out, byte_strobe, active);
  modport slave  (input serial_in, output data_out, valid_out, byte_strobe, active);
endinterface

// File: rtl/phy_rx_serial_paral_shift8.sv
// Bit capture for one lane: shift register plus 3-bit bit-position counter.
// byte_now_o is the byte that would complete on the current edge.
module phy_rx_shift8 (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       serial_i,
  input  logic       realign_i,
  output logic [7:0] byte_now_o,
  output logic       byte_done_o
);
  // Only the 7 most recent bits are ever needed; the 8th comes straight from serial_i.
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] bit_cnt_d;

  assign byte_now_o  = {shift_q, serial_i};
  assign byte_done_o = (bit_cnt_q == 3'd7) || realign_i;

  // A realign restarts the byte framing exactly as a normal wrap would.
  always_comb begin
    bit_cnt_d = bit_cnt_q + 3'd1;
    if (realign_i) bit_cnt_d = '0;
  end

  // Shift in one bit per cycle and advance the bit position.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= byte_now_o[6:0];
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/phy_rx_serial_paral.sv
// Per-lane PHY RX deserializer: locks onto COM idle bytes, then delivers
// payload bytes with a valid flag and a one-cycle byte strobe.
// Build option RX_ALIGN_HUNT_EN: bit-level COM hunt while searching.
module phy_rx_serial_paral
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COM_BYTE  = COM_BYTE_DEF,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic                 clk_8f,
  input  logic                 reset,
  phy_rx_serial_paral_if.slave rx
);
  localparam logic [COM_CNT_W-1:0] COM_CNT_TGT = COM_CNT_W'(COM_COUNT);

  rx_state_e             state_q, state_d;
  logic [COM_CNT_W-1:0]  com_cnt_q, com_cnt_d, com_cnt_inc;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  strobe_q, strobe_d;
  logic [7:0]            byte_now;
  logic                  byte_done;
  logic                  is_com;
  logic                  realign;

  assign is_com      = (byte_now == COM_BYTE);
  assign com_cnt_inc = sat_inc(com_cnt_q);

`ifdef RX_ALIGN_HUNT_EN
  // Any COM seen at any bit offset while searching defines the byte boundary.
  assign realign = (state_q == SEARCH) && is_com;
`else
  assign realign = 1'b0;
`endif

  phy_rx_shift8 u_shift8 (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .serial_i    (rx.serial_in),
    .realign_i   (realign),
    .byte_now_o  (byte_now),
    .byte_done_o (byte_done)
  );

  // FSM and COM-run counter state.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  // Next state and output values, evaluated only on byte completion.
  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    if (byte_done) begin
      strobe_d = 1'b1;
      data_d   = byte_now;
      valid_d  = 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (is_com) begin
            if (com_cnt_inc >= COM_CNT_TGT) begin
              state_d   = ACTIVE;
              com_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_inc;
            end
          end else begin
            com_cnt_d = '0;
          end
        end
        ACTIVE: valid_d = !is_com;
        default: state_d = SEARCH;
      endcase
    end
  end

  // Registered byte outputs.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign rx.data_out    = data_q;
  assign rx.valid_out   = valid_q;
  assign rx.byte_strobe = strobe_q;
  assign rx.active      = (state_q == ACTIVE);
endmodule

// File: tb/tb_phy_rx_serial_paral.sv
// Directed bench for phy_rx_serial_paral (RX_ALIGN_HUNT_EN adds the bit-hunt case).
module tb_phy_rx_serial_paral;
  localparam logic [7:0] COM = 8'hBC;

  logic        clk_8f = 1'b0;
  logic        reset;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        strobe_mid;

  always #5 clk_8f = ~clk_8f;

  phy_rx_serial_paral_if bus ();

  phy_rx_serial_paral #(
    .COM_BYTE  (8'hBC),
    .COM_COUNT (4)
  ) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .rx     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte MSB first; returns #1 after the edge sampling its last bit.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_8f);
      bus.serial_in = b[i];
      @(posedge clk_8f);
      #1;
      if (i == 7) strobe_mid = bus.byte_strobe;
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk_8f);
    bus.serial_in = v;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".strobe"},     bus.byte_strobe, 1'b1);
    chk({tag, ".strobe_mid"}, strobe_mid,      1'b0);
    chk({tag, ".data"},       bus.data_out,    d);
    chk({tag, ".valid"},      bus.valid_out,   v);
    chk({tag, ".active"},     bus.active,      a);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release after 3 edges.
  task automatic do_reset(input string tag);
    @(posedge clk_8f);
    #2 reset = 1'b0;
    #1;
    chk({tag, ".rst_data"},   bus.data_out,    8'h00);
    chk({tag, ".rst_valid"},  bus.valid_out,   1'b0);
    chk({tag, ".rst_strobe"}, bus.byte_strobe, 1'b0);
    chk({tag, ".rst_active"}, bus.active,      1'b0);
    repeat (3) @(posedge clk_8f);
    #1 reset = 1'b1;
    bus.serial_in = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b0;
    bus.serial_in = 1'b0;
    repeat (2) @(posedge clk_8f);
    #1;
    chk("por.data",   bus.data_out,    8'h00);
    chk("por.valid",  bus.valid_out,   1'b0);
    chk("por.strobe", bus.byte_strobe, 1'b0);
    chk("por.active", bus.active,      1'b0);
    reset = 1'b1;

    // T1: stream, reset mid-byte, boundary restarts from release
    send_byte(8'h55); chk_out("t1.b0", 8'h55, 1'b0, 1'b0);
    send_byte(8'h55); chk_out("t1.b1", 8'h55, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    do_reset("t1");
    send_byte(8'h5A); chk_out("t1.after", 8'h5A, 1'b0, 1'b0);

    // T2 + T4: lock on 4 COM, then payload and COM idle in ACTIVE
    do_reset("t2");
    send_byte(COM); chk_out("t2.c1", COM, 1'b0, 1'b0);
    send_byte(COM); chk_out("t2.c2", COM, 1'b0, 1'b0);
    send_byte(COM); chk_out("t2.c3", COM, 1'b0, 1'b0);
    send_byte(COM); chk_out("t2.c4", COM, 1'b0, 1'b1);
    send_byte(8'hA5); chk_out("t2.a5", 8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C); chk_out("t2.3c", 8'h3C, 1'b1, 1'b1);
    send_byte(8'hA5); chk_out("t4.a5", 8'hA5, 1'b1, 1'b1);
    send_byte(COM);   chk_out("t4.bc", COM,   1'b0, 1'b1);
    send_byte(8'h5A); chk_out("t4.5a", 8'h5A, 1'b1, 1'b1);

    // T3: a non-COM byte breaks the run
    do_reset("t3");
    for (int i = 0; i < 3; i++) begin
      send_byte(COM); chk_out("t3.pre", COM, 1'b0, 1'b0);
    end
    send_byte(8'h11); chk_out("t3.brk", 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(COM); chk_out("t3.run", COM, 1'b0, (i == 3) ? 1'b1 : 1'b0);
    end

`ifdef RX_ALIGN_HUNT_EN
    // T5: COM stream offset by 3 bits from reset release
    do_reset("t5");
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(COM); chk_out("t5.com", COM, 1'b0, (i == 3) ? 1'b1 : 1'b0);
    end
    send_byte(8'hF0); chk_out("t5.f0", 8'hF0, 1'b1, 1'b1);
`endif

    // T6: serializer-style stream of random payload with COM idle gaps
    do_reset("t6");
    for (int i = 0; i < 4; i++) send_byte(COM);
    chk("t6.lock", bus.active, 1'b1);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == COM) b = 8'h3C;
      if ($urandom_range(0, 1) == 1) begin
        send_byte(COM); chk_out("t6.idle", COM, 1'b0, 1'b1);
      end
      send_byte(b); chk_out("t6.data", b, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
